predec_class_dispatch: RTL and testbench
========================================

PREDEC_CLASS_DISPATCH -- requirements
Module: predec_class_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning input FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter ALU_CRED, default 4, meaning ALU port credits; LSU_CRED default 2, meaning LSU port credits; BR_CRED default 2, meaning branch port credits; FPU_CRED default 2, meaning FPU port credits.
REQ-003 SHALL have port clk, input, 1, meaning the single clock.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port in_vld/in_rdy, input/output, 1/1, meaning the valid/ready push handshake.
REQ-006 SHALL have port in_instr, input, 32, meaning the instruction word; in_class, input, 13, meaning the predecode class vector.
REQ-007 SHALL have, per port P in {alu,lsu,br,fpu}, port P_vld, output, 1; P_instr, output, 32; P_class, output, 13; and P_cred_ret, input, 1, meaning one credit returned.
REQ-008 SHALL have port alu_illeg, output, 1, meaning the ALU-issued op has an empty class.
REQ-009 SHALL have port cred_err, output, 1, meaning sticky flag: credit returned above maximum.

Function
REQ-010 SHALL push an entry when in_vld&&in_rdy; in_rdy=1 iff the FIFO is not full; a push and a pop in the same cycle are legal when full.
REQ-011 SHALL issue strictly in order from the FIFO head, at most one op per cycle.
REQ-012 SHALL select the head's port by priority: SYS -> serialize; JUMP|INDIR -> br; LOAD|STORE|STORE2|LOADFPU -> lsu; FPU -> fpu; ALU|SHIFT|MUL -> alu; none set -> alu with alu_illeg=1.
REQ-013 SHALL issue the head only if the selected port's credit counter is >0; issue pulses P_vld for 1 cycle, decrements the counter, and pops the FIFO.
REQ-014 SHALL register all outputs, giving a latency of 1 cycle from push to earliest P_vld on an empty FIFO.
REQ-015 SHALL increment a counter on P_cred_ret; a same-cycle issue and return on one port leaves it unchanged.
REQ-016 SHALL hold a counter at its maximum and set cred_err when a return would exceed the maximum.
REQ-017 SHALL run a state machine RUN -> DRAIN when the head is SYS; DRAIN -> SYSI when all counters are at maximum; SYSI issues the op on the br port with no credit consumed, then returns to RUN; pushes continue meanwhile.
REQ-018 SHALL keep all P_vld outputs 0 in DRAIN.

Reset
REQ-019 SHALL, on rst=0, asynchronously clear the FIFO; set in_rdy=0, all P_vld=0, alu_illeg=0 and cred_err=0; load counters to maximum; and set state=RUN.
REQ-020 SHALL drive in_rdy=1 from the first clk edge after reset deassertion.
REQ-021 SHALL, on reset mid-operation, drop in-flight ops with no outputs glitching to 1.

Configuration
REQ-022 SHALL, with PREDEC_DISPATCH_FPU_EN defined, include the fpu port and its counter.
REQ-023 SHALL, with PREDEC_DISPATCH_FPU_EN undefined, omit the fpu ports and send FPU-class ops to alu with alu_illeg=1.

Structure
REQ-024 SHALL place in shared package predec_pkg: the class-bit index constants (ALU=0, SHIFT=1, MUL=2, LOAD=3, STORE=4, STORE2=5, FPU=6, LOADFPU=7, SYS=8, JUMP=9, INDIR=10, POS0=11, RSV=12), the port-select enum and the state enum.
REQ-025 SHALL implement the credit counter as sub-module predec_cred_cnt, instantiated once per port.

Verification
REQ-026 Bench SHALL cover: after reset, push 5 ALU ops with alu_cred_ret=0 -> 4 alu_vld pulses, then a stall until one return, then the 5th issues.
REQ-027 Bench SHALL cover: push LOAD, JUMP, class=0 back-to-back -> lsu_vld, br_vld, then alu_vld with alu_illeg=1, on consecutive cycles.
REQ-028 Bench SHALL cover: issue 1 LSU op, then push SYS -> no issue until lsu_cred_ret, then br_vld carrying SYS, and the following ALU op issues the next cycle.
REQ-029 Bench SHALL cover: FIFO full (4) with in_vld held and a pop in the same cycle -> in_rdy stays 1 and the count stays 4.
REQ-030 Bench SHALL cover: alu_cred_ret with the counter at 4 -> cred_err=1 and the counter stays 4.
REQ-031 Bench SHALL cover: with PREDEC_DISPATCH_FPU_EN undefined, push an FPU op -> alu_vld=1 and alu_illeg=1.

Source files
------------

// File: rtl/predec_pkg.sv
// Shared definitions for the predecode class dispatcher: class-bit indices,
// port-select and dispatch-state enums, and the class-to-port decoder.
package predec_pkg;

    localparam int CLS_W = 13;

    localparam int CLS_ALU     = 0;
    localparam int CLS_SHIFT   = 1;
    localparam int CLS_MUL     = 2;
    localparam int CLS_LOAD    = 3;
    localparam int CLS_STORE   = 4;
    localparam int CLS_STORE2  = 5;
    localparam int CLS_FPU     = 6;
    localparam int CLS_LOADFPU = 7;
    localparam int CLS_SYS     = 8;
    localparam int CLS_JUMP    = 9;
    localparam int CLS_INDIR   = 10;
    localparam int CLS_POS0    = 11;
    localparam int CLS_RSV     = 12;

    typedef enum logic [2:0] {
        PORT_ALU = 3'd0,
        PORT_LSU = 3'd1,
        PORT_BR  = 3'd2,
        PORT_FPU = 3'd3,
        PORT_SYS = 3'd4
    } port_sel_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SYSI  = 2'd2
    } disp_state_e;

    typedef struct packed {
        port_sel_e port;
        logic      illeg;
    } port_dec_t;

    // Priority decode of a class vector. SYS wins over everything and
    // requests serialization; FPU ops fall back to ALU (flagged illegal)
    // when the FPU port is not built. POS0/RSV do not steer the op.
    function automatic port_dec_t decode_port(input logic [CLS_W-1:0] cls,
                                              input logic fpu_en);
        port_dec_t d;
        d.port  = PORT_ALU;
        d.illeg = 1'b0;
        if (cls[CLS_SYS]) begin
            d.port = PORT_SYS;
        end else if (cls[CLS_JUMP] || cls[CLS_INDIR]) begin
            d.port = PORT_BR;
        end else if (cls[CLS_LOAD] || cls[CLS_STORE] || cls[CLS_STORE2] || cls[CLS_LOADFPU]) begin
            d.port = PORT_LSU;
        end else if (cls[CLS_FPU]) begin
            if (fpu_en) begin
                d.port = PORT_FPU;
            end else begin
                d.port  = PORT_ALU;
                d.illeg = 1'b1;
            end
        end else if (cls[CLS_ALU] || cls[CLS_SHIFT] || cls[CLS_MUL]) begin
            d.port = PORT_ALU;
        end else begin
            d.port  = PORT_ALU;
            d.illeg = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/predec_class_dispatch_cred_cnt.sv
// Per-port credit counter. Starts full, decrements on take, increments on
// return; a simultaneous take and return cancel. A return at the maximum
// is held off and reported on ovf for the caller to latch.
module predec_cred_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic take,
    input  logic ret,
    output logic avail,
    output logic full,
    output logic ovf
);

    localparam int             CW     = $clog2(MAX + 1);
    localparam logic [CW-1:0]  MAX_V  = CW'(MAX);
    localparam logic [CW-1:0]  ONE_V  = CW'(1);
    localparam logic [CW-1:0]  ZERO_V = CW'(0);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          ovf_s;

    // Next credit count and overflow detection
    always_comb begin
        cnt_s = cnt_r;
        ovf_s = 1'b0;
        if (take && !ret) begin
            cnt_s = cnt_r - ONE_V;
        end else if (ret && !take) begin
            if (cnt_r == MAX_V) begin
                cnt_s = cnt_r;
                ovf_s = 1'b1;
            end else begin
                cnt_s = cnt_r + ONE_V;
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Credit count register, loaded full on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= MAX_V;
        end else begin
            cnt_r <= cnt_s;
        end
    end

    assign avail = (cnt_r != ZERO_V);
    assign full  = (cnt_r == MAX_V);
    assign ovf   = ovf_s;

endmodule

// File: rtl/predec_class_dispatch.sv
// Predecode class dispatcher: in-order FIFO of predecoded ops, issued one per
// cycle to the alu/lsu/br(/fpu) ports under per-port credits, with SYS ops
// serialized behind a full credit drain and issued on the branch port.
// Optional FPU port and counter: define PREDEC_DISPATCH_FPU_EN.
module predec_class_dispatch
    import predec_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ALU_CRED = 4,
    parameter int LSU_CRED = 2,
    parameter int BR_CRED  = 2
`ifdef PREDEC_DISPATCH_FPU_EN
    ,
    parameter int FPU_CRED = 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [31:0]      in_instr,
    input  logic [CLS_W-1:0] in_class,
    output logic             alu_vld,
    output logic [31:0]      alu_instr,
    output logic [CLS_W-1:0] alu_class,
    input  logic             alu_cred_ret,
    output logic             lsu_vld,
    output logic [31:0]      lsu_instr,
    output logic [CLS_W-1:0] lsu_class,
    input  logic             lsu_cred_ret,
    output logic             br_vld,
    output logic [31:0]      br_instr,
    output logic [CLS_W-1:0] br_class,
    input  logic             br_cred_ret,
`ifdef PREDEC_DISPATCH_FPU_EN
    output logic             fpu_vld,
    output logic [31:0]      fpu_instr,
    output logic [CLS_W-1:0] fpu_class,
    input  logic             fpu_cred_ret,
`endif
    output logic             alu_illeg,
    output logic             cred_err
);

`ifdef PREDEC_DISPATCH_FPU_EN
    localparam logic FPU_EN = 1'b1;
`else
    localparam logic FPU_EN = 1'b0;
`endif

    localparam int             AW      = $clog2(DEPTH);
    localparam int             FCW     = AW + 1;
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [FCW-1:0] CNT_ONE = FCW'(1);
    localparam logic [FCW-1:0] CNT_ZER = FCW'(0);
    localparam logic [FCW-1:0] CNT_FUL = FCW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [31:0]      instr_mem_r [DEPTH];
    logic [CLS_W-1:0] cls_mem_r   [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [FCW-1:0]   fifo_cnt_r;
    logic             rdy_en_r;

    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_s;
    logic [31:0]      head_instr_s;
    logic [CLS_W-1:0] head_cls_s;
    port_dec_t        dec_s;

    disp_state_e      state_r;
    disp_state_e      state_s;
    port_sel_e        iss_port_s;
    logic             iss_illeg_s;
    logic             port_avail_s;

    logic alu_take_s, lsu_take_s, br_take_s;
    logic alu_avail_s, lsu_avail_s, br_avail_s;
    logic alu_full_s, lsu_full_s, br_full_s;
    logic alu_ovf_s, lsu_ovf_s, br_ovf_s;
    logic all_full_s;
    logic any_ovf_s;
    logic alu_iss_s, lsu_iss_s, br_iss_s;

    logic             alu_vld_r, lsu_vld_r, br_vld_r, alu_illeg_r, cred_err_r;
    logic [31:0]      alu_instr_r, lsu_instr_r, br_instr_r;
    logic [CLS_W-1:0] alu_class_r, lsu_class_r, br_class_r;

`ifdef PREDEC_DISPATCH_FPU_EN
    logic             fpu_take_s, fpu_avail_s, fpu_full_s, fpu_ovf_s, fpu_iss_s;
    logic             fpu_vld_r;
    logic [31:0]      fpu_instr_r;
    logic [CLS_W-1:0] fpu_class_r;
`endif

    assign empty_s      = (fifo_cnt_r == CNT_ZER);
    assign full_s       = (fifo_cnt_r == CNT_FUL);
    assign head_instr_s = instr_mem_r[rd_ptr_r];
    assign head_cls_s   = cls_mem_r[rd_ptr_r];
    assign dec_s        = decode_port(head_cls_s, FPU_EN);

    // A pop this cycle frees a slot, so a full FIFO still accepts a push
    assign in_rdy = rdy_en_r && (!full_s || pop_s);
    assign push_s = in_vld && in_rdy;

`ifdef PREDEC_DISPATCH_FPU_EN
    assign all_full_s = alu_full_s && lsu_full_s && br_full_s && fpu_full_s;
    assign any_ovf_s  = alu_ovf_s || lsu_ovf_s || br_ovf_s || fpu_ovf_s;
`else
    assign all_full_s = alu_full_s && lsu_full_s && br_full_s;
    assign any_ovf_s  = alu_ovf_s || lsu_ovf_s || br_ovf_s;
`endif

    // Credit availability for the port the head op decodes to
    always_comb begin
        port_avail_s = 1'b0;
        case (dec_s.port)
            PORT_ALU: port_avail_s = alu_avail_s;
            PORT_LSU: port_avail_s = lsu_avail_s;
            PORT_BR:  port_avail_s = br_avail_s;
`ifdef PREDEC_DISPATCH_FPU_EN
            PORT_FPU: port_avail_s = fpu_avail_s;
`endif
            default:  port_avail_s = 1'b0;
        endcase
    end

    // Dispatch FSM next state and issue decision
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        iss_port_s  = dec_s.port;
        iss_illeg_s = dec_s.illeg;
        case (state_r)
            ST_RUN: begin
                if (empty_s) begin
                    pop_s = 1'b0;
                end else if (dec_s.port == PORT_SYS) begin
                    state_s = ST_DRAIN;
                end else if (port_avail_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (all_full_s) begin
                    state_s = ST_SYSI;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_SYSI: begin
                // Head is the SYS op that caused the drain; it goes out on br for free
                pop_s       = 1'b1;
                iss_port_s  = PORT_BR;
                iss_illeg_s = 1'b0;
                state_s     = ST_RUN;
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // Per-port issue strobes and credit consumption (SYS issue is credit-free)
    always_comb begin
        alu_iss_s  = pop_s && (iss_port_s == PORT_ALU);
        lsu_iss_s  = pop_s && (iss_port_s == PORT_LSU);
        br_iss_s   = pop_s && (iss_port_s == PORT_BR);
        alu_take_s = alu_iss_s && (state_r == ST_RUN);
        lsu_take_s = lsu_iss_s && (state_r == ST_RUN);
        br_take_s  = br_iss_s && (state_r == ST_RUN);
`ifdef PREDEC_DISPATCH_FPU_EN
        fpu_iss_s  = pop_s && (iss_port_s == PORT_FPU);
        fpu_take_s = fpu_iss_s && (state_r == ST_RUN);
`endif
    end

    predec_cred_cnt #(.MAX(ALU_CRED)) u_alu_cred (
        .clk(clk), .rst(rst), .take(alu_take_s), .ret(alu_cred_ret),
        .avail(alu_avail_s), .full(alu_full_s), .ovf(alu_ovf_s)
    );
    predec_cred_cnt #(.MAX(LSU_CRED)) u_lsu_cred (
        .clk(clk), .rst(rst), .take(lsu_take_s), .ret(lsu_cred_ret),
        .avail(lsu_avail_s), .full(lsu_full_s), .ovf(lsu_ovf_s)
    );
    predec_cred_cnt #(.MAX(BR_CRED)) u_br_cred (
        .clk(clk), .rst(rst), .take(br_take_s), .ret(br_cred_ret),
        .avail(br_avail_s), .full(br_full_s), .ovf(br_ovf_s)
    );
`ifdef PREDEC_DISPATCH_FPU_EN
    predec_cred_cnt #(.MAX(FPU_CRED)) u_fpu_cred (
        .clk(clk), .rst(rst), .take(fpu_take_s), .ret(fpu_cred_ret),
        .avail(fpu_avail_s), .full(fpu_full_s), .ovf(fpu_ovf_s)
    );
`endif

    // FIFO payload write; contents are don't-care once pointers are reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= in_instr;
            cls_mem_r[wr_ptr_r]   <= in_class;
        end
    end

    // FIFO pointers, occupancy, ready enable and dispatch state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= CNT_ZER;
            rdy_en_r   <= 1'b0;
            state_r    <= ST_RUN;
        end else begin
            rdy_en_r <= 1'b1;
            state_r  <= state_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Registered port outputs and sticky credit error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_vld_r   <= 1'b0;
            lsu_vld_r   <= 1'b0;
            br_vld_r    <= 1'b0;
            alu_illeg_r <= 1'b0;
            cred_err_r  <= 1'b0;
            alu_instr_r <= 32'h0;
            lsu_instr_r <= 32'h0;
            br_instr_r  <= 32'h0;
            alu_class_r <= '0;
            lsu_class_r <= '0;
            br_class_r  <= '0;
        end else begin
            alu_vld_r   <= alu_iss_s;
            lsu_vld_r   <= lsu_iss_s;
            br_vld_r    <= br_iss_s;
            alu_illeg_r <= alu_iss_s && iss_illeg_s;
            cred_err_r  <= cred_err_r || any_ovf_s;
            if (alu_iss_s) begin
                alu_instr_r <= head_instr_s;
                alu_class_r <= head_cls_s;
            end
            if (lsu_iss_s) begin
                lsu_instr_r <= head_instr_s;
                lsu_class_r <= head_cls_s;
            end
            if (br_iss_s) begin
                br_instr_r <= head_instr_s;
                br_class_r <= head_cls_s;
            end
        end
    end

`ifdef PREDEC_DISPATCH_FPU_EN
    // Registered FPU port outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpu_vld_r   <= 1'b0;
            fpu_instr_r <= 32'h0;
            fpu_class_r <= '0;
        end else begin
            fpu_vld_r <= fpu_iss_s;
            if (fpu_iss_s) begin
                fpu_instr_r <= head_instr_s;
                fpu_class_r <= head_cls_s;
            end
        end
    end

    assign fpu_vld   = fpu_vld_r;
    assign fpu_instr = fpu_instr_r;
    assign fpu_class = fpu_class_r;
`endif

    assign alu_vld   = alu_vld_r;
    assign alu_instr = alu_instr_r;
    assign alu_class = alu_class_r;
    assign lsu_vld   = lsu_vld_r;
    assign lsu_instr = lsu_instr_r;
    assign lsu_class = lsu_class_r;
    assign br_vld    = br_vld_r;
    assign br_instr  = br_instr_r;
    assign br_class  = br_class_r;
    assign alu_illeg = alu_illeg_r;
    assign cred_err  = cred_err_r;

endmodule

// File: tb/tb_predec_class_dispatch.sv
// Directed bench for predec_class_dispatch (default build, DEPTH=4,
// ALU/LSU/BR credits 4/2/2). Inputs change and outputs are sampled 1 ns
// after each rising edge.
module tb_predec_class_dispatch;
    import predec_pkg::*;

    localparam logic [12:0] C_NONE = 13'h0000;
    localparam logic [12:0] C_ALU  = 13'h0001;
    localparam logic [12:0] C_LOAD = 13'h0008;
    localparam logic [12:0] C_FPU  = 13'h0040;
    localparam logic [12:0] C_SYS  = 13'h0100;
    localparam logic [12:0] C_JUMP = 13'h0200;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld, in_rdy;
    logic [31:0] in_instr;
    logic [12:0] in_class;
    logic        alu_vld, lsu_vld, br_vld;
    logic [31:0] alu_instr, lsu_instr, br_instr;
    logic [12:0] alu_class, lsu_class, br_class;
    logic        alu_cred_ret, lsu_cred_ret, br_cred_ret;
    logic        alu_illeg, cred_err;
`ifdef PREDEC_DISPATCH_FPU_EN
    logic        fpu_vld, fpu_cred_ret;
    logic [31:0] fpu_instr;
    logic [12:0] fpu_class;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int pulses;

    always #5 clk = ~clk;

    predec_class_dispatch dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_instr(in_instr), .in_class(in_class),
        .alu_vld(alu_vld), .alu_instr(alu_instr), .alu_class(alu_class), .alu_cred_ret(alu_cred_ret),
        .lsu_vld(lsu_vld), .lsu_instr(lsu_instr), .lsu_class(lsu_class), .lsu_cred_ret(lsu_cred_ret),
        .br_vld(br_vld), .br_instr(br_instr), .br_class(br_class), .br_cred_ret(br_cred_ret),
`ifdef PREDEC_DISPATCH_FPU_EN
        .fpu_vld(fpu_vld), .fpu_instr(fpu_instr), .fpu_class(fpu_class), .fpu_cred_ret(fpu_cred_ret),
`endif
        .alu_illeg(alu_illeg), .cred_err(cred_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_vld = 1'b0; in_instr = 32'h0; in_class = C_NONE;
        alu_cred_ret = 1'b0; lsu_cred_ret = 1'b0; br_cred_ret = 1'b0;
`ifdef PREDEC_DISPATCH_FPU_EN
        fpu_cred_ret = 1'b0;
`endif
        #2;
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_alu_vld", alu_vld, 0);
        chk("rst_lsu_vld", lsu_vld, 0);
        chk("rst_br_vld", br_vld, 0);
        chk("rst_alu_illeg", alu_illeg, 0);
        chk("rst_cred_err", cred_err, 0);
        step(); step();
        rst = 1'b1;
        step();
        chk("rdy_after_rst", in_rdy, 1);

        // Five ALU ops, no returns: four issue, then stall until one credit
        for (int i = 0; i < 5; i++) begin
            in_vld = 1'b1; in_instr = 32'hA000_0000 + i; in_class = C_ALU;
            step();
            if (i == 0) begin
                chk("alu_first_lat", alu_vld, 0);
            end else begin
                chk("alu_burst_vld", alu_vld, 1);
                chk("alu_burst_instr", alu_instr, 32'hA000_0000 + i - 1);
            end
        end
        in_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("alu_stall", alu_vld, 0);
        end
        alu_cred_ret = 1'b1; step(); alu_cred_ret = 1'b0;
        chk("alu_ret_edge", alu_vld, 0);
        step();
        chk("alu_fifth_vld", alu_vld, 1);
        chk("alu_fifth_instr", alu_instr, 32'hA000_0004);
        alu_cred_ret = 1'b1;
        for (int i = 0; i < 4; i++) step();
        alu_cred_ret = 1'b0;
        step();
        chk("alu_refill_no_err", cred_err, 0);

        // LOAD, JUMP, empty class back-to-back
        in_vld = 1'b1; in_instr = 32'hB000_0001; in_class = C_LOAD; step();
        in_instr = 32'hB000_0002; in_class = C_JUMP; step();
        chk("mix_lsu_vld", lsu_vld, 1);
        chk("mix_lsu_instr", lsu_instr, 32'hB000_0001);
        chk("mix_br_idle", br_vld, 0);
        in_instr = 32'hB000_0003; in_class = C_NONE; step();
        in_vld = 1'b0;
        chk("mix_br_vld", br_vld, 1);
        chk("mix_br_instr", br_instr, 32'hB000_0002);
        chk("mix_lsu_idle", lsu_vld, 0);
        step();
        chk("mix_alu_vld", alu_vld, 1);
        chk("mix_alu_illeg", alu_illeg, 1);
        chk("mix_alu_instr", alu_instr, 32'hB000_0003);
        chk("mix_br_done", br_vld, 0);
        step();
        chk("mix_illeg_clr", alu_illeg, 0);
        alu_cred_ret = 1'b1; lsu_cred_ret = 1'b1; br_cred_ret = 1'b1; step();
        alu_cred_ret = 1'b0; lsu_cred_ret = 1'b0; br_cred_ret = 1'b0; step();
        chk("mix_refill_no_err", cred_err, 0);

        // LSU op in flight, then SYS waits for the drain, then an ALU op
        in_vld = 1'b1; in_instr = 32'hC000_0001; in_class = C_LOAD; step();
        in_instr = 32'hC000_0002; in_class = C_SYS; step();
        chk("sys_lsu_vld", lsu_vld, 1);
        in_instr = 32'hC000_0003; in_class = C_ALU; step();
        in_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sys_drain_br", br_vld, 0);
            chk("sys_drain_alu", alu_vld, 0);
            step();
        end
        lsu_cred_ret = 1'b1; step(); lsu_cred_ret = 1'b0;
        chk("sys_ret_edge_br", br_vld, 0);
        step();
        chk("sys_sysi_br", br_vld, 0);
        chk("sys_sysi_alu", alu_vld, 0);
        step();
        chk("sys_br_vld", br_vld, 1);
        chk("sys_br_instr", br_instr, 32'hC000_0002);
        chk("sys_br_class", br_class, C_SYS);
        step();
        chk("sys_next_alu_vld", alu_vld, 1);
        chk("sys_next_alu_instr", alu_instr, 32'hC000_0003);
        chk("sys_next_br_idle", br_vld, 0);
        alu_cred_ret = 1'b1; step(); alu_cred_ret = 1'b0;

        // Fill the FIFO behind a credit-starved LSU head, then push+pop at full
        in_vld = 1'b1; in_instr = 32'hD000_0001; in_class = C_LOAD; step();
        in_instr = 32'hD000_0002; step();
        in_vld = 1'b0; step(); step();
        for (int k = 0; k < 4; k++) begin
            in_vld = 1'b1; in_instr = 32'hD000_0003 + k; in_class = C_LOAD;
            step();
        end
        in_instr = 32'hD000_0007;
        chk("full_rdy_low", in_rdy, 0);
        chk("full_cnt", dut.fifo_cnt_r, 4);
        step();
        chk("full_hold_rdy", in_rdy, 0);
        chk("full_hold_cnt", dut.fifo_cnt_r, 4);
        lsu_cred_ret = 1'b1; step(); lsu_cred_ret = 1'b0;
        chk("full_pop_rdy", in_rdy, 1);
        step();
        in_vld = 1'b0;
        chk("full_pushpop_cnt", dut.fifo_cnt_r, 4);
        chk("full_pushpop_vld", lsu_vld, 1);
        chk("full_pushpop_instr", lsu_instr, 32'hD000_0003);
        chk("full_after_rdy", in_rdy, 0);
        for (int k = 0; k < 4; k++) begin
            lsu_cred_ret = 1'b1; step(); lsu_cred_ret = 1'b0; step();
            chk("drain_lsu_vld", lsu_vld, 1);
            chk("drain_lsu_instr", lsu_instr, 32'hD000_0004 + k);
        end
        lsu_cred_ret = 1'b1; step(); step(); lsu_cred_ret = 1'b0; step();
        chk("lsu_refill_no_err", cred_err, 0);

        // Return on a full ALU counter: sticky error, counter stays at 4
        alu_cred_ret = 1'b1; step(); alu_cred_ret = 1'b0;
        chk("cred_err_set", cred_err, 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 5) begin
                in_vld = 1'b1; in_instr = 32'hE000_0000 + i; in_class = C_ALU;
            end else begin
                in_vld = 1'b0;
            end
            step();
            if (alu_vld === 1'b1) pulses++;
        end
        chk("alu_max_hold", pulses, 4);
        chk("cred_err_sticky", cred_err, 1);
        alu_cred_ret = 1'b1; step(); alu_cred_ret = 1'b0; step();
        chk("ovf_fifth_vld", alu_vld, 1);
        chk("ovf_fifth_instr", alu_instr, 32'hE000_0004);
        alu_cred_ret = 1'b1;
        for (int i = 0; i < 4; i++) step();
        alu_cred_ret = 1'b0;

        // Reset in the middle of traffic drops the queued op
        in_vld = 1'b1; in_instr = 32'hF000_0001; in_class = C_ALU; step();
        in_instr = 32'hF000_0002; step();
        in_vld = 1'b0;
        chk("mid_pre_alu_vld", alu_vld, 1);
        rst = 1'b0; #1;
        chk("mid_rst_alu_vld", alu_vld, 0);
        chk("mid_rst_in_rdy", in_rdy, 0);
        chk("mid_rst_cred_err", cred_err, 0);
        step();
        rst = 1'b1;
        step();
        chk("mid_rdy_back", in_rdy, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_dropped", alu_vld, 0);
        end

`ifdef PREDEC_DISPATCH_FPU_EN
        in_vld = 1'b1; in_instr = 32'h9000_0001; in_class = C_FPU; step();
        in_vld = 1'b0; step();
        chk("fpu_vld", fpu_vld, 1);
        chk("fpu_instr", fpu_instr, 32'h9000_0001);
        chk("fpu_not_alu", alu_vld, 0);
`else
        in_vld = 1'b1; in_instr = 32'h9000_0001; in_class = C_FPU; step();
        in_vld = 1'b0; step();
        chk("fpu_to_alu_vld", alu_vld, 1);
        chk("fpu_to_alu_illeg", alu_illeg, 1);
        chk("fpu_to_alu_instr", alu_instr, 32'h9000_0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
